// File: rtl/bank_ring_pkg.sv
// Shared constants for the bank ring handoff buffer: error bit positions and
// default geometry.
package bank_ring_pkg;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;
  localparam int ERR_W   = 2;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_NBANK  = 2;

endpackage

// File: rtl/bank_ram.sv
// Single-write, single-read synchronous RAM holding all banks back to back,
// addressed as {bank, word}, with a registered read port.
module bank_ram
  import bank_ring_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NBANK  = DEF_NBANK,
  localparam int BANK_W = $clog2(NBANK),
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [BANK_W-1:0] wbank_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [BANK_W-1:0] rbank_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [NBANK*DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{wbank_i, waddr_i}] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[{rbank_i, raddr_i}];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bank_ring_buffer.sv
// Ring of NBANK handoff banks between a producer and a consumer port.
// Optional build macro BANK_RING_AUTO_COMMIT_EN: a write to the last word commits the bank.
module bank_ring_buffer
  import bank_ring_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NBANK  = DEF_NBANK,
  localparam int BANK_W = $clog2(NBANK),
  localparam int CNT_W  = $clog2(NBANK + 1),
  localparam int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_cs,
  input  logic [ADDR_W-1:0] prod_addr,
  input  logic [DATA_W-1:0] prod_data,
  input  logic              prod_commit,
  input  logic [LEN_W-1:0]  prod_len,
  output logic              prod_ready,
  output logic [BANK_W-1:0] wr_bank,
  input  logic              cons_cs,
  input  logic [ADDR_W-1:0] cons_addr,
  output logic [DATA_W-1:0] cons_data,
  input  logic              cons_release,
  output logic              cons_valid,
  output logic [LEN_W-1:0]  cons_len,
  output logic [BANK_W-1:0] rd_bank,
  output logic [CNT_W-1:0]  level,
  output logic [ERR_W-1:0]  err
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(DEPTH);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NBANK - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NBANK);

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  // Explicit wrap so non-power-of-two ring sizes work.
  function automatic logic [BANK_W-1:0] ring_inc(input logic [BANK_W-1:0] ptr);
    return (ptr == LAST_BANK) ? '0 : ptr + 1'b1;
  endfunction

  logic [BANK_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [BANK_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [LEN_W-1:0]  len_q [NBANK];

  logic              wr_ok;
  logic              auto_commit;
  logic              commit_ok;
  logic              rel_ok;
  logic [LEN_W-1:0]  commit_len;

  assign prod_ready = (count_q != FULL_CNT);
  assign cons_valid = (count_q != '0);
  assign level      = count_q;
  assign wr_bank    = wr_ptr_q;
  assign rd_bank    = rd_ptr_q;
  assign err        = err_q;
  assign cons_len   = len_q[rd_ptr_q];

  assign wr_ok  = prod_cs && prod_ready;
  assign rel_ok = cons_release && cons_valid;

`ifdef BANK_RING_AUTO_COMMIT_EN
  assign auto_commit = wr_ok && (prod_addr == '1);
`else
  assign auto_commit = 1'b0;
`endif

  // An auto-commit coinciding with prod_commit is still a single commit of a full bank.
  assign commit_ok  = (prod_commit || auto_commit) && prod_ready;
  assign commit_len = auto_commit ? LEN_MAX : sat_len(prod_len);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (commit_ok) begin
      wr_ptr_d = ring_inc(wr_ptr_q);
    end
    if (rel_ok) begin
      rd_ptr_d = ring_inc(rd_ptr_q);
    end
    case ({commit_ok, rel_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if ((prod_cs || prod_commit) && !prod_ready) begin
      err_d[ERR_OVF] = 1'b1;
    end
    if (cons_release && !cons_valid) begin
      err_d[ERR_UNF] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBANK; b++) begin
        len_q[b] <= '0;
      end
    end else if (commit_ok) begin
      len_q[wr_ptr_q] <= commit_len;
    end
  end

  // Write and read both use the pre-update pointers, so same-cycle
  // commit/release act on the bank that was current before the edge.
  bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NBANK  (NBANK)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_ok),
    .wbank_i (wr_ptr_q),
    .waddr_i (prod_addr),
    .wdata_i (prod_data),
    .re_i    (cons_cs),
    .rbank_i (rd_ptr_q),
    .raddr_i (cons_addr),
    .rdata_o (cons_data)
  );

endmodule

// File: doc/bank_ring_buffer.md
# bank_ring_buffer

Parametrised multi-bank handoff buffer between the 6502 host port and the QOI engine port. It replaces the fixed two-buffer, `sel`-switched scheme with a ring of NBANK equal banks. The producer fills a bank and commits it. The consumer reads committed banks in order and releases them. Full/empty tracking, per-bank committed length and sticky error reporting are all held in hardware. One instance per direction: host→engine for input pixels, engine→host for encoded output.

## Interface
Parameters:
- DATA_W, 8, word width
- ADDR_W, 10, bank address width; DEPTH = 2**ADDR_W words per bank
- NBANK, 2, bank count, ≥2 (any integer, not only powers of two)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- prod_cs  in  1  producer write strobe
- prod_addr  in  ADDR_W  producer word address within current bank
- prod_data  in  DATA_W  producer write data
- prod_commit  in  1  one-cycle pulse: hand current bank to consumer
- prod_len  in  ADDR_W+1  valid word count recorded on commit (0..DEPTH)
- prod_ready  out  1  a free bank is available to write
- wr_bank  out  $clog2(NBANK)  index of bank being written
- cons_cs  in  1  consumer read strobe
- cons_addr  in  ADDR_W  consumer word address within current bank
- cons_data  out  DATA_W  registered read data
- cons_release  in  1  one-cycle pulse: free current read bank
- cons_valid  out  1  at least one committed bank
- cons_len  out  ADDR_W+1  committed length of current read bank
- rd_bank  out  $clog2(NBANK)  index of bank being read
- level  out  $clog2(NBANK+1)  committed bank count
- err  out  2  sticky: bit0 overflow, bit1 underflow

## Operation
- Banks form a ring. wr_ptr, rd_ptr and count (0..NBANK) are registered. Both pointers wrap from NBANK-1 to 0 by explicit compare.
- prod_ready = (count != NBANK). cons_valid = (count != 0). level = count.
- Write: when prod_cs && prod_ready, store prod_data at mem[wr_ptr][prod_addr]. When not ready, the write is dropped and err[0] is set.
- Commit: when prod_commit && prod_ready, latch len[wr_ptr] = prod_len, advance wr_ptr and increment count. When full, the commit is ignored and err[0] is set.
- Release: when cons_release && cons_valid, advance rd_ptr and decrement count. When empty, the release is ignored and err[1] is set.
- Read: on cons_cs, cons_data <= mem[rd_ptr][cons_addr]. Reads while empty are permitted and return don't-care data, with no error. Without cons_cs, cons_data holds its value.
- cons_len = len[rd_ptr], combinational from the register.
- Simultaneous valid commit and release: both pointers advance and count is unchanged.
- Write and commit in the same cycle: the write lands in the pre-commit bank.
- Read and release in the same cycle: the read uses the pre-release bank.
- prod_len > DEPTH is saturated to DEPTH.
- Bank RAM contents are not cleared by reset. Reset mid-operation discards all committed banks.

## Timing
- Reset values: prod_ready=1, cons_valid=0, cons_data=0, cons_len=0, wr_bank=0, rd_bank=0, level=0, err=0.
- Write latency: data is readable by the consumer once its bank is committed.
- Commit to cons_valid: 1 cycle. A commit at edge N makes cons_valid high after edge N.
- Release to prod_ready (when full): 1 cycle.
- Read latency: 1 cycle. cons_data is valid the cycle after cons_cs.
- Error bits are set on the edge of the offending event and cleared only by rst_n.

## Configuration
- BANK_RING_AUTO_COMMIT_EN defined: a valid write to prod_addr == DEPTH-1 commits the bank on the same edge with len = DEPTH. This replaces the old last-address flag.
  - If prod_commit is also asserted that cycle, exactly one commit occurs, using len = DEPTH.
  - An auto-commit attempted when full is not possible, because the write itself is dropped and err[0] is set.
- BANK_RING_AUTO_COMMIT_EN undefined: only prod_commit commits; writes to the last address have no side effect.

## Structure
- bank_ring_pkg holds the err bit-index constants (ERR_OVF=0, ERR_UNF=1) and the default parameter constants.
- Sub-module bank_ram: a single 1W1R synchronous RAM of NBANK*DEPTH words, addressed {bank, addr}, with a registered read port. It replaces the tri-state ssram pair.
- Top level holds the pointers, count, length registers, error logic and auto-commit.

## Test plan
- Reset then idle: all outputs at reset values; prod_ready=1, level=0.
- Write 0xA5 at address 3 and commit with len=4 → cons_valid=1 next cycle, cons_len=4. Read address 3 → cons_data=0xA5 one cycle later. Release → level=0.
- NBANK=2: commit twice → prod_ready=0. A write of 0x11 is dropped and err=2'b01. Release → prod_ready=1 next cycle.
- Release while empty → err=2'b10, level stays 0, rd_bank stays 0.
- level=1 with commit and release on the same edge → level stays 1, wr_bank and rd_bank both advance, with wrap after NBANK-1.
- With BANK_RING_AUTO_COMMIT_EN defined: write to address 1023 → level increments and cons_len=1024. Without the macro: level unchanged. Assert rst_n low mid-stream → level=0 and err=0 immediately.
